controlador_cajero: RTL and testbench

Parametrised successor of the bank card controller. It runs one ATM session per card insertion: it collects a serially entered PIN and checks it against the card's PIN. After a correct PIN it performs one deposit or withdrawal against an internal balance register. Failed attempts are counted, with an advertencia level and a latching bloqueo. Widths, PIN length, retry limit and initial balance are parameters. An optional foreign-card fee is compiled in with a macro.

---
 rtl/controlador_cajero_pkg.sv | 38 +++
 rtl/controlador_cajero_if.sv | 40 ++++
 rtl/controlador_cajero_registro_pin.sv | 39 +++
 rtl/controlador_cajero.sv | 186 ++++++++++++++++++
 tb/tb_controlador_cajero.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/controlador_cajero_pkg.sv
// Shared types and helpers for the ATM session controller.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
package controlador_pkg;

    typedef enum logic [2:0] {
        ESPERA_TARJETA,
        INGRESO_PIN,
        VERIFICA_PIN,
        ESPERA_MONTO,
        FIN_SESION,
        BLOQUEADO
    } estado_t;

    // Transaction codes carried on tipo_transaccion
    localparam logic DEPOSITO = 1'b0;
    localparam logic RETIRO   = 1'b1;

    // Widest operand the saturating adder handles; callers pass their real width
    localparam int ANCHO_MAX = 128;

    // Unsigned add of two ancho-bit values, clamped to all-ones of that width
    function automatic logic [ANCHO_MAX-1:0] suma_saturada(
        input logic [ANCHO_MAX-1:0] a,
        input logic [ANCHO_MAX-1:0] b,
        input int unsigned          ancho
    );
        logic [ANCHO_MAX:0]   s;
        logic [ANCHO_MAX-1:0] tope;
        tope = {ANCHO_MAX{1'b1}} >> (ANCHO_MAX - ancho);
        s    = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, tope})
            return tope;
        else
            return s[ANCHO_MAX-1:0];
    endfunction

endpackage

// File: rtl/controlador_cajero_if.sv
// Card, keypad, amount and result signals of one ATM controller.
// Latency: none (wiring only).
// Backpressure: none; strobes are single-cycle and never stalled.
interface controlador_cajero_if #(
    parameter int PIN_DIGITS = 4,
    parameter int BAL_W      = 64,
    parameter int MONTO_W    = 32
);
    logic                    tarjeta_recibida;
    logic                    tipo_tarjeta;
    logic [4*PIN_DIGITS-1:0] pin;
    logic [3:0]              digito;
    logic                    digito_stb;
    logic                    tipo_transaccion;
    logic [MONTO_W-1:0]      monto;
    logic                    monto_stb;
    logic [BAL_W-1:0]        balance;
    logic                    balance_actualizado;
    logic                    entregar_dinero;
    logic                    fondos_insuficientes;
    logic                    pin_incorrecto;
    logic                    advertencia;
    logic                    bloqueo;
    logic                    comision;

    modport master (
        output tarjeta_recibida, tipo_tarjeta, pin, digito, digito_stb,
               tipo_transaccion, monto, monto_stb,
        input  balance, balance_actualizado, entregar_dinero, fondos_insuficientes,
               pin_incorrecto, advertencia, bloqueo, comision
    );

    modport slave (
        input  tarjeta_recibida, tipo_tarjeta, pin, digito, digito_stb,
               tipo_transaccion, monto, monto_stb,
        output balance, balance_actualizado, entregar_dinero, fondos_insuficientes,
               pin_incorrecto, advertencia, bloqueo, comision
    );

endinterface

// File: rtl/controlador_cajero_registro_pin.sv
// Shift buffer collecting entered PIN digits, MSD first, with a digit counter.
// Latency: digit stored on the edge its enable is sampled; done is combinational on that cycle.
// Backpressure: none; clr has priority over en.
module registro_pin #(
    parameter int PIN_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic [3:0]              digito,
    output logic [4*PIN_DIGITS-1:0] buffer,
    output logic                    done
);

    localparam int CW = $clog2(PIN_DIGITS + 1);

    logic [CW-1:0] cuenta;

    // Shift the new digit in at the LSB end and count it; clear wipes both
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buffer <= '0;
            cuenta <= '0;
        end else if (clr) begin
            buffer <= '0;
            cuenta <= '0;
        end else if (en) begin
            buffer <= (4*PIN_DIGITS)'({buffer, digito});
            cuenta <= cuenta + CW'(1);
        end
    end

    // High while the digit being captured is the last one of the PIN
    always_comb begin
        done = en && !clr && (cuenta == CW'(PIN_DIGITS - 1));
    end

endmodule

// File: rtl/controlador_cajero.sv
// ATM session controller: PIN check with retry lockout, one deposit/withdrawal per card.
// Latency: PIN verdict one edge after the last digit; transaction results on the monto_stb edge.
// Backpressure: none; strobes outside their state are dropped. Fee feature: COMISION_EN.
module controlador_cajero
    import controlador_pkg::*;
#(
    parameter int                PIN_DIGITS = 4,
    parameter int                MAX_TRIES  = 3,
    parameter int                BAL_W      = 64,
    parameter int                MONTO_W    = 32,
    parameter logic [BAL_W-1:0]  BAL_INIT   = 5000,
    parameter int unsigned       FEE        = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    controlador_cajero_if.slave  bus
);

    localparam int FW = $clog2(MAX_TRIES + 1);

    estado_t                 estado, estado_n;
    logic [BAL_W-1:0]        balance_q, balance_n;
    logic                    act_q, act_n;
    logic                    ent_q, ent_n;
    logic                    fondos_q, fondos_n;
    logic                    pinc_q, pinc_n;
    logic                    adv_q, adv_n;
    logic                    bloq_q, bloq_n;
    logic                    com_q, com_n;
    logic [FW-1:0]           fallos, fallos_n, fallos_inc;
    logic                    buf_clr, buf_en, pin_done;
    logic [4*PIN_DIGITS-1:0] buffer;
    logic [BAL_W:0]          total;
    logic [BAL_W-1:0]        balance_dep;
    logic                    aborta;

    // Digits only count while collecting a PIN with the card still present,
    // so a removal on the last digit never triggers a check
    assign buf_en = (estado == INGRESO_PIN) && bus.digito_stb && bus.tarjeta_recibida;

    registro_pin #(.PIN_DIGITS(PIN_DIGITS)) u_registro_pin (
        .clk    (clk),
        .rst    (rst),
        .clr    (buf_clr),
        .en     (buf_en),
        .digito (bus.digito),
        .buffer (buffer),
        .done   (pin_done)
    );

`ifdef COMISION_EN
    // Withdrawal debit including the other-bank fee, one bit wider than the balance
    assign total = (BAL_W+1)'(bus.monto) + (com_q ? (BAL_W+1)'(FEE) : '0);
`else
    assign total = (BAL_W+1)'(bus.monto);
    wire unused_ok = &{1'b0, bus.tipo_tarjeta, FEE[0]};
`endif

    assign balance_dep = BAL_W'(suma_saturada(ANCHO_MAX'(balance_q), ANCHO_MAX'(bus.monto), BAL_W));
    assign fallos_inc  = fallos + FW'(1);

    // Card pulled while a session is in progress abandons it
    assign aborta = !bus.tarjeta_recibida &&
                    ((estado == INGRESO_PIN) || (estado == VERIFICA_PIN) || (estado == ESPERA_MONTO));

    // Next-state and next-output logic for the session FSM
    always_comb begin
        estado_n  = estado;
        balance_n = balance_q;
        act_n     = 1'b0;
        ent_n     = 1'b0;
        fondos_n  = 1'b0;
        pinc_n    = 1'b0;
        adv_n     = adv_q;
        bloq_n    = bloq_q;
        com_n     = com_q;
        fallos_n  = fallos;
        buf_clr   = 1'b0;

        if (aborta) begin
            // Failure count and advertencia survive so reinsertion cannot reset attempts
            estado_n = ESPERA_TARJETA;
            buf_clr  = 1'b1;
            com_n    = 1'b0;
        end else begin
            case (estado)
                ESPERA_TARJETA: begin
                    if (bus.tarjeta_recibida) begin
                        estado_n = INGRESO_PIN;
                        buf_clr  = 1'b1;
`ifdef COMISION_EN
                        com_n    = bus.tipo_tarjeta;
`endif
                    end
                end
                INGRESO_PIN: begin
                    if (pin_done)
                        estado_n = VERIFICA_PIN;
                end
                VERIFICA_PIN: begin
                    if (buffer == bus.pin) begin
                        fallos_n = '0;
                        adv_n    = 1'b0;
                        estado_n = ESPERA_MONTO;
                    end else begin
                        pinc_n   = 1'b1;
                        fallos_n = fallos_inc;
                        if (fallos_inc == FW'(MAX_TRIES)) begin
                            bloq_n   = 1'b1;
                            estado_n = BLOQUEADO;
                        end else begin
                            if (fallos_inc == FW'(MAX_TRIES - 1))
                                adv_n = 1'b1;
                            buf_clr  = 1'b1;
                            estado_n = INGRESO_PIN;
                        end
                    end
                end
                ESPERA_MONTO: begin
                    if (bus.monto_stb) begin
                        estado_n = FIN_SESION;
                        if (bus.tipo_transaccion == DEPOSITO) begin
                            balance_n = balance_dep;
                            act_n     = 1'b1;
                        end else if (total <= {1'b0, balance_q}) begin
                            balance_n = balance_q - total[BAL_W-1:0];
                            ent_n     = 1'b1;
                            act_n     = 1'b1;
                        end else begin
                            fondos_n  = 1'b1;
                        end
                    end
                end
                FIN_SESION: begin
                    if (!bus.tarjeta_recibida) begin
                        estado_n = ESPERA_TARJETA;
                        com_n    = 1'b0;
                    end
                end
                BLOQUEADO: begin
                    estado_n = BLOQUEADO;
                end
                default: begin
                    estado_n = ESPERA_TARJETA;
                end
            endcase
        end
    end

    // State, balance and every output are registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado    <= ESPERA_TARJETA;
            balance_q <= BAL_INIT;
            act_q     <= 1'b0;
            ent_q     <= 1'b0;
            fondos_q  <= 1'b0;
            pinc_q    <= 1'b0;
            adv_q     <= 1'b0;
            bloq_q    <= 1'b0;
            com_q     <= 1'b0;
            fallos    <= '0;
        end else begin
            estado    <= estado_n;
            balance_q <= balance_n;
            act_q     <= act_n;
            ent_q     <= ent_n;
            fondos_q  <= fondos_n;
            pinc_q    <= pinc_n;
            adv_q     <= adv_n;
            bloq_q    <= bloq_n;
            com_q     <= com_n;
            fallos    <= fallos_n;
        end
    end

    assign bus.balance              = balance_q;
    assign bus.balance_actualizado  = act_q;
    assign bus.entregar_dinero      = ent_q;
    assign bus.fondos_insuficientes = fondos_q;
    assign bus.pin_incorrecto       = pinc_q;
    assign bus.advertencia          = adv_q;
    assign bus.bloqueo              = bloq_q;
    assign bus.comision             = com_q;

endmodule

// File: tb/tb_controlador_cajero.sv
// Directed bench for controlador_cajero with default parameters and pin 16'h3721.
// Latency: checks PIN verdicts one edge after the last digit and transactions on the strobe edge.
// Backpressure: not applicable; all waits are fixed cycle counts.
module tb_controlador_cajero;
    import controlador_pkg::*;

    logic clk;
    logic rst;
    int   n_asserts;
    int   n_fail;

    controlador_cajero_if #(.PIN_DIGITS(4), .BAL_W(64), .MONTO_W(32)) ifc ();

    controlador_cajero dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic enter_pin(input logic [15:0] p);
        for (int i = 3; i >= 0; i--) begin
            ifc.digito     = p[i*4 +: 4];
            ifc.digito_stb = 1'b1;
            tick();
        end
        ifc.digito_stb = 1'b0;
    endtask

    task automatic transaccion(input logic tipo, input logic [31:0] m);
        ifc.tipo_transaccion = tipo;
        ifc.monto            = m;
        ifc.monto_stb        = 1'b1;
        tick();
        ifc.monto_stb        = 1'b0;
    endtask

    // Insert card, enter the right PIN and wait for the verdict edge
    task automatic sesion_ok(input logic tipo);
        ifc.tipo_tarjeta     = tipo;
        ifc.tarjeta_recibida = 1'b1;
        tick();
        enter_pin(16'h3721);
        tick();
    endtask

    task automatic retira_tarjeta();
        ifc.tarjeta_recibida = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        ifc.tarjeta_recibida = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_asserts = 0;
        n_fail    = 0;
        ifc.tarjeta_recibida = 1'b0;
        ifc.tipo_tarjeta     = 1'b0;
        ifc.pin              = 16'h3721;
        ifc.digito           = 4'd0;
        ifc.digito_stb       = 1'b0;
        ifc.tipo_transaccion = 1'b0;
        ifc.monto            = 32'd0;
        ifc.monto_stb        = 1'b0;
        rst = 1'b1;
        tick();

        // Reset values
        check("rst_balance", ifc.balance, 64'd5000);
        check("rst_outs", 64'({ifc.balance_actualizado, ifc.entregar_dinero, ifc.fondos_insuficientes,
                               ifc.pin_incorrecto, ifc.advertencia, ifc.bloqueo, ifc.comision}), 64'd0);
        check("rst_state", 64'(dut.estado), 64'(ESPERA_TARJETA));
        rst = 1'b0;

        // Correct PIN then deposit 1000
        ifc.tarjeta_recibida = 1'b1;
        tick();
        check("ins_state", 64'(dut.estado), 64'(INGRESO_PIN));
        enter_pin(16'h3721);
        check("verif_state", 64'(dut.estado), 64'(VERIFICA_PIN));
        tick();
        check("ok_state", 64'(dut.estado), 64'(ESPERA_MONTO));
        check("ok_nopinc", ifc.pin_incorrecto, 64'd0);
        transaccion(DEPOSITO, 32'd1000);
        check("dep_act", ifc.balance_actualizado, 64'd1);
        check("dep_bal", ifc.balance, 64'd6000);
        check("dep_noent", ifc.entregar_dinero, 64'd0);
        tick();
        check("dep_pulse1", ifc.balance_actualizado, 64'd0);
        check("dep_fin", 64'(dut.estado), 64'(FIN_SESION));
        retira_tarjeta();
        check("fin_state", 64'(dut.estado), 64'(ESPERA_TARJETA));

        // Withdraw exactly the balance, then one more than the balance
        do_reset();
        check("rst2_bal", ifc.balance, 64'd5000);
        sesion_ok(1'b0);
        transaccion(RETIRO, 32'd5000);
        check("ret_ent", ifc.entregar_dinero, 64'd1);
        check("ret_act", ifc.balance_actualizado, 64'd1);
        check("ret_bal", ifc.balance, 64'd0);
        tick();
        check("ret_pulse1", ifc.entregar_dinero, 64'd0);
        retira_tarjeta();
        sesion_ok(1'b0);
        transaccion(RETIRO, 32'd5001);
        check("nof_flag", ifc.fondos_insuficientes, 64'd1);
        check("nof_noent", ifc.entregar_dinero, 64'd0);
        check("nof_noact", ifc.balance_actualizado, 64'd0);
        check("nof_bal", ifc.balance, 64'd0);
        retira_tarjeta();

        // Three wrong PINs lead to lockout
        do_reset();
        ifc.tarjeta_recibida = 1'b1;
        tick();
        enter_pin(16'h1111);
        tick();
        check("w1_pinc", ifc.pin_incorrecto, 64'd1);
        check("w1_adv", ifc.advertencia, 64'd0);
        check("w1_state", 64'(dut.estado), 64'(INGRESO_PIN));
        enter_pin(16'h1111);
        tick();
        check("w2_pinc", ifc.pin_incorrecto, 64'd1);
        check("w2_adv", ifc.advertencia, 64'd1);
        check("w2_bloq", ifc.bloqueo, 64'd0);
        enter_pin(16'h1111);
        tick();
        check("w3_pinc", ifc.pin_incorrecto, 64'd1);
        check("w3_bloq", ifc.bloqueo, 64'd1);
        check("w3_state", 64'(dut.estado), 64'(BLOQUEADO));
        enter_pin(16'h3721);
        tick();
        check("blk_state", 64'(dut.estado), 64'(BLOQUEADO));
        check("blk_pinc", ifc.pin_incorrecto, 64'd0);
        transaccion(RETIRO, 32'd100);
        check("blk_bal", ifc.balance, 64'd5000);
        check("blk_noent", ifc.entregar_dinero, 64'd0);
        do_reset();
        check("clr_bloq", ifc.bloqueo, 64'd0);
        check("clr_adv", ifc.advertencia, 64'd0);
        check("clr_state", 64'(dut.estado), 64'(ESPERA_TARJETA));

        // Failure count survives card removal
        ifc.tarjeta_recibida = 1'b1;
        tick();
        enter_pin(16'h1111);
        tick();
        enter_pin(16'h1111);
        tick();
        retira_tarjeta();
        check("keep_state", 64'(dut.estado), 64'(ESPERA_TARJETA));
        check("keep_adv", ifc.advertencia, 64'd1);
        ifc.tarjeta_recibida = 1'b1;
        tick();
        enter_pin(16'h1111);
        tick();
        check("keep_bloq", ifc.bloqueo, 64'd1);

        // Digit above 9 is stored and simply mismatches
        do_reset();
        ifc.tarjeta_recibida = 1'b1;
        tick();
        enter_pin(16'hA721);
        tick();
        check("hex_pinc", ifc.pin_incorrecto, 64'd1);
        retira_tarjeta();

        // Removal on the last digit: no check happens
        do_reset();
        ifc.tarjeta_recibida = 1'b1;
        tick();
        for (int i = 3; i >= 1; i--) begin
            ifc.digito     = 4'(i);
            ifc.digito_stb = 1'b1;
            tick();
        end
        ifc.digito           = 4'd1;
        ifc.tarjeta_recibida = 1'b0;
        tick();
        ifc.digito_stb = 1'b0;
        check("abd_state", 64'(dut.estado), 64'(ESPERA_TARJETA));
        tick();
        check("abd_pinc", ifc.pin_incorrecto, 64'd0);

        // Removal on the monto_stb cycle: no transaction
        sesion_ok(1'b0);
        check("abm_pre", 64'(dut.estado), 64'(ESPERA_MONTO));
        ifc.tarjeta_recibida = 1'b0;
        transaccion(RETIRO, 32'd100);
        check("abm_noent", ifc.entregar_dinero, 64'd0);
        check("abm_noact", ifc.balance_actualizado, 64'd0);
        check("abm_bal", ifc.balance, 64'd5000);
        check("abm_state", 64'(dut.estado), 64'(ESPERA_TARJETA));

`ifdef COMISION_EN
        // Other-bank card pays the fee on withdrawal
        do_reset();
        sesion_ok(1'b1);
        check("fee_com", ifc.comision, 64'd1);
        transaccion(RETIRO, 32'd4990);
        check("fee_ent", ifc.entregar_dinero, 64'd1);
        check("fee_bal", ifc.balance, 64'd0);
        retira_tarjeta();
        check("fee_comclr", ifc.comision, 64'd0);
        do_reset();
        sesion_ok(1'b1);
        transaccion(RETIRO, 32'd4991);
        check("fee_nof", ifc.fondos_insuficientes, 64'd1);
        check("fee_nofbal", ifc.balance, 64'd5000);
        retira_tarjeta();
`else
        // Without the fee build an other-bank card pays nothing extra
        do_reset();
        sesion_ok(1'b1);
        check("nofee_com", ifc.comision, 64'd0);
        transaccion(RETIRO, 32'd5000);
        check("nofee_ent", ifc.entregar_dinero, 64'd1);
        check("nofee_bal", ifc.balance, 64'd0);
        retira_tarjeta();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
